// File: rtl/sbox_share_ctrl.sv
// ============================================================================
// Module      : sbox_share_ctrl
// Description : Time-shares one external combinational S-box between a
//               128-bit SubBytes job and a 32-bit SubWord job, one byte/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_share_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         kw_req,
    input  logic [31:0]  kw_data,
    output logic         kw_ack,
    output logic         kw_done,
    output logic [31:0]  kw_result,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
    output logic         busy
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_RUN_ST   = 2'd1;
    localparam logic [1:0] c_RUN_KW   = 2'd2;
    localparam logic       c_GRANT_KW = 1'b0;
    localparam logic       c_GRANT_ST = 1'b1;
    localparam logic [3:0] c_LAST_ST  = 4'd15;
    localparam logic [3:0] c_LAST_KW  = 4'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_stateNext;
    logic [3:0]   r_byteCnt;
    logic         r_lastGrant;
    logic [127:0] r_src;
    logic [127:0] r_work;

    logic         w_idle;
    logic         w_grantSt;
    logic         w_grantKw;
    logic         w_lastByte;
    logic [6:0]   w_bitIdx;
    logic [7:0]   w_srcByte;
    logic [127:0] w_workNext;

    assign w_idle = (r_state == c_IDLE);

    // Ties go to whoever was not served last; nothing is granted during reset.
    assign w_grantSt = w_idle & ~rst & st_req & (~kw_req | (r_lastGrant == c_GRANT_KW));
    assign w_grantKw = w_idle & ~rst & kw_req & (~st_req | (r_lastGrant == c_GRANT_ST));

    assign st_ack = w_grantSt;
    assign kw_ack = w_grantKw;
    assign busy   = ~w_idle;

    assign w_lastByte = ((r_state == c_RUN_ST) && (r_byteCnt == c_LAST_ST)) ||
                        ((r_state == c_RUN_KW) && (r_byteCnt == c_LAST_KW));

    // Byte k lives at bits [127-8k -: 8]; for a 4-bit k that offset is {~k, 3'b000}.
    assign w_bitIdx = {~r_byteCnt, 3'b000};

    always_comb begin
        w_srcByte             = r_src[w_bitIdx +: 8];
        w_workNext            = r_work;
        w_workNext[w_bitIdx +: 8] = sbox_out;
    end

    assign sbox_in = w_idle ? 8'h00 : w_srcByte;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grantSt) begin
                    w_stateNext = c_RUN_ST;
                end else if (w_grantKw) begin
                    w_stateNext = c_RUN_KW;
                end
            end
            c_RUN_ST, c_RUN_KW: begin
                if (w_lastByte) begin
                    w_stateNext = c_IDLE;
                end
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrant <= c_GRANT_ST;
        end else if (w_grantSt) begin
            r_lastGrant <= c_GRANT_ST;
        end else if (w_grantKw) begin
            r_lastGrant <= c_GRANT_KW;
        end
    end

    // The word job is parked in the top bytes so both jobs share one byte index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src     <= 128'h0;
            r_byteCnt <= 4'd0;
            r_work    <= 128'h0;
        end else if (w_grantSt) begin
            r_src     <= st_data;
            r_byteCnt <= 4'd0;
        end else if (w_grantKw) begin
            r_src     <= {kw_data, 96'h0};
            r_byteCnt <= 4'd0;
        end else if (!w_idle) begin
            r_work    <= w_workNext;
            r_byteCnt <= r_byteCnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_done   <= 1'b0;
            kw_done   <= 1'b0;
            st_result <= 128'h0;
            kw_result <= 32'h0;
        end else begin
            st_done <= 1'b0;
            kw_done <= 1'b0;
            if (w_lastByte && (r_state == c_RUN_ST)) begin
                st_done   <= 1'b1;
                st_result <= w_workNext;
            end
            if (w_lastByte && (r_state == c_RUN_KW)) begin
                kw_done   <= 1'b1;
                kw_result <= w_workNext[127:96];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sbox_share_ctrl.sv
// ============================================================================
// Module      : tb_sbox_share_ctrl
// Description : Directed bench for sbox_share_ctrl using an AES S-box table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sbox_share_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         st_req;
    logic [127:0] st_data;
    logic         st_ack;
    logic         st_done;
    logic [127:0] st_result;
    logic         kw_req;
    logic [31:0]  kw_data;
    logic         kw_ack;
    logic         kw_done;
    logic [31:0]  kw_result;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic         busy;

    always #5 clk = ~clk;

    logic [0:255][7:0] sboxTab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    assign sbox_out = sboxTab[sbox_in];

    sbox_share_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .st_req    (st_req),
        .st_data   (st_data),
        .st_ack    (st_ack),
        .st_done   (st_done),
        .st_result (st_result),
        .kw_req    (kw_req),
        .kw_data   (kw_data),
        .kw_ack    (kw_ack),
        .kw_done   (kw_done),
        .kw_result (kw_result),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .busy      (busy)
    );

    int nPass  = 0;
    int nTotal = 0;
    logic [127:0] expSt = 128'h0;
    logic [31:0]  expKw = 32'h0;

    typedef struct {
        bit           isSt;
        logic [127:0] data;
        logic [127:0] expRes;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        nTotal++;
        if (act === req) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [7:0] byteOf(input bit isSt, input logic [127:0] data, input int k);
        logic [7:0] b;
        if (isSt) b = data[127 - 8*k -: 8];
        else      b = data[31 - 8*k -: 8];
        return b;
    endfunction

    // Starts at the drive phase of a fresh cycle; returns at the negedge of the ack cycle.
    task automatic startJob(input bit isSt, input logic [127:0] data);
        @(posedge clk); #1;
        if (isSt) begin st_req = 1'b1; st_data = data; end
        else      begin kw_req = 1'b1; kw_data = data[31:0]; end
        @(negedge clk);
        chk(isSt ? "st_ack" : "kw_ack", isSt ? st_ack : kw_ack, 1);
        chk(isSt ? "kw_ack_idle" : "st_ack_idle", isSt ? kw_ack : st_ack, 0);
    endtask

    // Called at the negedge of the ack cycle; returns at the negedge of the done cycle.
    task automatic finishJob(input bit isSt, input logic [127:0] data, input logic [127:0] expRes,
                             input bit hold, input bit ackSt, input bit ackKw);
        int n = isSt ? 16 : 4;
        @(posedge clk); #1;
        if (!hold) begin
            if (isSt) begin st_req = 1'b0; st_data = ~st_data; end
            else      begin kw_req = 1'b0; kw_data = ~kw_data; end
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("busy_run", busy, 1);
            chk("sbox_in_seq", sbox_in, byteOf(isSt, data, k));
            chk("acks_run", {st_ack, kw_ack}, 2'b00);
            chk("done_early", {st_done, kw_done}, 2'b00);
            @(posedge clk); #1;
        end
        @(negedge clk);
        if (isSt) expSt = expRes;
        else      expKw = expRes[31:0];
        chk("done_pulse", {st_done, kw_done}, isSt ? 2'b10 : 2'b01);
        chk("st_result", st_result, expSt);
        chk("kw_result", kw_result, expKw);
        chk("busy_done", busy, 0);
        chk("sbox_in_idle", sbox_in, 0);
        chk("acks_done", {st_ack, kw_ack}, {ackSt, ackKw});
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expSt = 128'h0;
        expKw = 32'h0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
        vecs[1] = '{1'b0, 128'hcf4f3c09, 128'h8a84eb01};
        vecs[2] = '{1'b1, 128'h52e99f5352e99f5352e99f5352e99f53, 128'h001edbed001edbed001edbed001edbed};
        vecs[3] = '{1'b0, 128'h52e99f53, 128'h001edbed};
        vecs[4] = '{1'b0, 128'h00000000, 128'h63636363};

        // Reset with a pending state request: no ack while rst is high.
        rst = 1'b1; st_req = 1'b1; st_data = 128'h0; kw_req = 1'b0; kw_data = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ack_in_reset", {st_ack, kw_ack}, 2'b00);
        chk("reset_busy", busy, 0);
        chk("reset_done", {st_done, kw_done}, 2'b00);
        chk("reset_st_result", st_result, 0);
        chk("reset_kw_result", kw_result, 0);
        chk("reset_sbox_in", sbox_in, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_ack_after_reset", st_ack, 1);
        finishJob(1'b1, 128'h0, {16{8'h63}}, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            startJob(vecs[i].isSt, vecs[i].data);
            finishJob(vecs[i].isSt, vecs[i].data, vecs[i].expRes, 1'b0, 1'b0, 1'b0);
        end

        // Simultaneous requests after reset: kw first, then alternate.
        doReset();
        @(posedge clk); #1;
        st_req = 1'b1; st_data = 128'h000102030405060708090a0b0c0d0e0f;
        kw_req = 1'b1; kw_data = 32'hcf4f3c09;
        @(negedge clk);
        chk("tie1_acks", {st_ack, kw_ack}, 2'b01);
        finishJob(1'b0, 128'hcf4f3c09, 128'h8a84eb01, 1'b1, 1'b1, 1'b0);
        finishJob(1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h637c777bf26b6fc53001672bfed7ab76, 1'b1, 1'b0, 1'b1);
        finishJob(1'b0, 128'hcf4f3c09, 128'h8a84eb01, 1'b0, 1'b1, 1'b0);
        finishJob(1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h637c777bf26b6fc53001672bfed7ab76, 1'b0, 1'b0, 1'b0);

        // Continuous state request: re-acked in each done cycle.
        startJob(1'b1, {4{32'h52e99f53}});
        finishJob(1'b1, {4{32'h52e99f53}}, {4{32'h001edbed}}, 1'b1, 1'b1, 1'b0);
        finishJob(1'b1, {4{32'h52e99f53}}, {4{32'h001edbed}}, 1'b0, 1'b0, 1'b0);

        // Abort a state job with reset during its eighth byte cycle.
        startJob(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        @(posedge clk); #1;
        st_req = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        expSt = 128'h0;
        expKw = 32'h0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_st_result", st_result, 0);
        chk("abort_kw_result", kw_result, 0);
        for (int c = 0; c < 20; c++) begin
            chk("abort_no_done", {st_done, kw_done}, 2'b00);
            @(negedge clk);
        end
        startJob(1'b0, 128'hcf4f3c09);
        finishJob(1'b0, 128'hcf4f3c09, 128'h8a84eb01, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

`default_nettype wire
